// File: rtl/cplx_mult_acc.sv
// Frame-based complex multiply-accumulate: pairs stream-1 and stream-2 samples,
// multiplies them and sums the products over each stream-1 sof..eof frame.
module cplx_mult_acc #(
    parameter int DATA_SIZE = 16,
    parameter int ACC_SIZE  = 48
) (
    input  logic                        data_clk_i,
    input  logic                        data_rst_i,
    input  logic signed [DATA_SIZE-1:0] data1_i_i,
    input  logic signed [DATA_SIZE-1:0] data1_q_i,
    input  logic                        data1_en_i,
    input  logic                        data1_sof_i,
    input  logic                        data1_eof_i,
    input  logic signed [DATA_SIZE-1:0] data2_i_i,
    input  logic signed [DATA_SIZE-1:0] data2_q_i,
    input  logic                        data2_en_i,
    output logic signed [ACC_SIZE-1:0]  data_i_o,
    output logic signed [ACC_SIZE-1:0]  data_q_o,
    output logic                        data_en_o,
    output logic                        data_sof_o,
    output logic                        data_eof_o,
    output logic                        err_o,
    output logic                        data_rst_o,
    output logic                        data_clk_o
);

    localparam int PW = 2 * DATA_SIZE;
    localparam int SW = PW + 1;

    logic signed [DATA_SIZE-1:0] h1_i, h1_q, h2_i, h2_q;
    logic                        h1_vld, h1_sof, h1_eof, h2_vld;
    logic                        fire, drop;

    logic signed [PW-1:0]        p_rr, p_ii, p_ri, p_ir;
    logic                        p_vld, p_sof, p_eof;

    logic signed [SW-1:0]        s_re, s_im;
    logic                        s_vld, s_sof, s_eof;

    logic signed [ACC_SIZE-1:0]  acc_i, acc_q, t_i, t_q, sum_i, sum_q;
    logic                        in_frame;

    assign data_rst_o = data_rst_i;
    assign data_clk_o = data_clk_i;
    assign data_sof_o = data_en_o;
    assign data_eof_o = data_en_o;

    assign fire = h1_vld & h2_vld;
    // A new sample may only replace a hold that is empty or being consumed this cycle.
    assign drop = (data1_en_i & h1_vld & ~fire) | (data2_en_i & h2_vld & ~fire);

    assign t_i   = ACC_SIZE'(s_re);
    assign t_q   = ACC_SIZE'(s_im);
    assign sum_i = acc_i + t_i;
    assign sum_q = acc_q + t_q;

    always_ff @(posedge data_clk_i) begin
        if (data_rst_i) begin
            h1_vld <= 1'b0;
            h1_sof <= 1'b0;
            h1_eof <= 1'b0;
            h1_i   <= '0;
            h1_q   <= '0;
        end else if (data1_en_i && (!h1_vld || fire)) begin
            h1_vld <= 1'b1;
            h1_sof <= data1_sof_i;
            h1_eof <= data1_eof_i;
            h1_i   <= data1_i_i;
            h1_q   <= data1_q_i;
        end else if (fire) begin
            h1_vld <= 1'b0;
        end
    end

    always_ff @(posedge data_clk_i) begin
        if (data_rst_i) begin
            h2_vld <= 1'b0;
            h2_i   <= '0;
            h2_q   <= '0;
        end else if (data2_en_i && (!h2_vld || fire)) begin
            h2_vld <= 1'b1;
            h2_i   <= data2_i_i;
            h2_q   <= data2_q_i;
        end else if (fire) begin
            h2_vld <= 1'b0;
        end
    end

    always_ff @(posedge data_clk_i) begin
        if (data_rst_i) begin
            p_vld <= 1'b0;
            p_sof <= 1'b0;
            p_eof <= 1'b0;
            p_rr  <= '0;
            p_ii  <= '0;
            p_ri  <= '0;
            p_ir  <= '0;
            s_vld <= 1'b0;
            s_sof <= 1'b0;
            s_eof <= 1'b0;
            s_re  <= '0;
            s_im  <= '0;
        end else begin
            p_vld <= fire;
            p_sof <= h1_sof;
            p_eof <= h1_eof;
            p_rr  <= PW'(h1_i) * PW'(h2_i);
            p_ii  <= PW'(h1_q) * PW'(h2_q);
            p_ri  <= PW'(h1_i) * PW'(h2_q);
            p_ir  <= PW'(h1_q) * PW'(h2_i);
            s_vld <= p_vld;
            s_sof <= p_sof;
            s_eof <= p_eof;
            // Extra bit: (-2^(N-1))^2 twice overflows the product width.
            s_re  <= SW'(p_rr) - SW'(p_ii);
            s_im  <= SW'(p_ri) + SW'(p_ir);
        end
    end

    always_ff @(posedge data_clk_i) begin
        if (data_rst_i) begin
            acc_i     <= '0;
            acc_q     <= '0;
            in_frame  <= 1'b0;
            data_i_o  <= '0;
            data_q_o  <= '0;
            data_en_o <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            data_en_o <= 1'b0;
            if (drop) err_o <= 1'b1;
            if (s_vld) begin
                if (s_sof) begin
                    if (in_frame) err_o <= 1'b1;
                    if (s_eof) begin
                        data_i_o  <= t_i;
                        data_q_o  <= t_q;
                        data_en_o <= 1'b1;
                        in_frame  <= 1'b0;
                        acc_i     <= '0;
                        acc_q     <= '0;
                    end else begin
                        acc_i    <= t_i;
                        acc_q    <= t_q;
                        in_frame <= 1'b1;
                    end
                end else if (in_frame) begin
                    if (s_eof) begin
                        data_i_o  <= sum_i;
                        data_q_o  <= sum_q;
                        data_en_o <= 1'b1;
                        in_frame  <= 1'b0;
                        acc_i     <= '0;
                        acc_q     <= '0;
                    end else begin
                        acc_i <= sum_i;
                        acc_q <= sum_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cplx_mult_acc.sv
// Self-checking bench for cplx_mult_acc: vector table, random frames against a
// complex-sum reference, and hand sequences for skew, drop, restart and reset.
module tb_cplx_mult_acc;

    localparam int DS = 16;
    localparam int AS = 48;

    logic                 data_clk_i = 1'b0;
    logic                 data_rst_i;
    logic signed [DS-1:0] data1_i_i, data1_q_i, data2_i_i, data2_q_i;
    logic                 data1_en_i, data1_sof_i, data1_eof_i, data2_en_i;
    logic signed [AS-1:0] data_i_o, data_q_o;
    logic                 data_en_o, data_sof_o, data_eof_o, err_o, data_rst_o, data_clk_o;

    cplx_mult_acc #(.DATA_SIZE(DS), .ACC_SIZE(AS)) dut (
        .data_clk_i(data_clk_i), .data_rst_i(data_rst_i),
        .data1_i_i(data1_i_i), .data1_q_i(data1_q_i), .data1_en_i(data1_en_i),
        .data1_sof_i(data1_sof_i), .data1_eof_i(data1_eof_i),
        .data2_i_i(data2_i_i), .data2_q_i(data2_q_i), .data2_en_i(data2_en_i),
        .data_i_o(data_i_o), .data_q_o(data_q_o), .data_en_o(data_en_o),
        .data_sof_o(data_sof_o), .data_eof_o(data_eof_o), .err_o(err_o),
        .data_rst_o(data_rst_o), .data_clk_o(data_clk_o)
    );

    always #5 data_clk_i = ~data_clk_i;

    typedef struct {
        logic signed [AS-1:0] i;
        logic signed [AS-1:0] q;
        int                   cyc;
        logic                 sof;
        logic                 eof;
    } res_t;

    typedef struct {
        int     n;
        int     ar[4];
        int     ai[4];
        int     br[4];
        int     bi[4];
        longint ei;
        longint eq;
    } vec_t;

    res_t rq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial forever begin
        @(posedge data_clk_i);
        cyc++;
        #1;
        if (data_en_o) rq.push_back('{data_i_o, data_q_o, cyc, data_sof_o, data_eof_o});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(string name, logic signed [63:0] act, logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge data_clk_i);
        #1;
    endtask

    task automatic set_in(bit e1, bit s, bit e, int ar, int ai, bit e2, int br, int bi);
        data1_en_i  = e1;
        data1_sof_i = s;
        data1_eof_i = e;
        data1_i_i   = DS'(ar);
        data1_q_i   = DS'(ai);
        data2_en_i  = e2;
        data2_i_i   = DS'(br);
        data2_q_i   = DS'(bi);
    endtask

    task automatic idle(int n);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        data_rst_i = 1'b1;
        idle(2);
        data_rst_i = 1'b0;
        rq.delete();
    endtask

    // Expects exactly one result pulse since the last queue flush.
    task automatic check_one(string name, longint ei, longint eq, int exp_cyc);
        res_t r;
        check({name, " pulse count"}, rq.size(), 1);
        if (rq.size() > 0) begin
            r = rq.pop_front();
            check({name, " real"}, r.i, ei);
            check({name, " imag"}, r.q, eq);
            check({name, " latency"}, r.cyc, exp_cyc);
            check({name, " sof/eof"}, {r.sof, r.eof}, 2'b11);
        end
        rq.delete();
    endtask

    task automatic drive_frame(vec_t v, output int eof_cyc);
        eof_cyc = 0;
        for (int k = 0; k < v.n; k++) begin
            set_in(1, k == 0, k == v.n - 1, v.ar[k], v.ai[k], 1, v.br[k], v.bi[k]);
            if (k == v.n - 1) eof_cyc = cyc;
            tick();
        end
        idle(10);
    endtask

    vec_t vt[5];

    initial begin
        int     ec;
        int     n;
        int     ar[8], ai[8], br[8], bi[8];
        longint mi, mq;

        vt[0] = '{4, '{3, 3, 3, 3}, '{4, 4, 4, 4}, '{1, 1, 1, 1}, '{-2, -2, -2, -2}, 44, -8};
        vt[1] = '{1, '{-32768, 0, 0, 0}, '{-32768, 0, 0, 0}, '{-32768, 0, 0, 0},
                  '{-32768, 0, 0, 0}, 0, 64'sd2147483648};
        vt[2] = '{3, '{-5, -5, -5, 0}, '{7, 7, 7, 0}, '{2, 2, 2, 0}, '{3, 3, 3, 0}, -93, -3};
        vt[3] = '{1, '{32767, 0, 0, 0}, '{-32768, 0, 0, 0}, '{-32768, 0, 0, 0},
                  '{32767, 0, 0, 0}, 0, 64'sd2147418113};
        vt[4] = '{2, '{1, 3, 0, 0}, '{2, -1, 0, 0}, '{4, 0, 0, 0}, '{0, 5, 0, 0}, 9, 23};

        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        data_rst_i = 1'b1;
        repeat (3) tick();
        check("reset real", data_i_o, 0);
        check("reset imag", data_q_o, 0);
        check("reset en", data_en_o, 0);
        check("reset err", err_o, 0);
        check("reset passthru", data_rst_o, 1);
        data_rst_i = 1'b0;
        tick();
        rq.delete();

        foreach (vt[v]) begin
            drive_frame(vt[v], ec);
            check_one($sformatf("vec%0d", v), vt[v].ei, vt[v].eq, ec + 4);
        end
        check("table err", err_o, 0);
        check("hold real", data_i_o, vt[4].ei);

        for (int r = 0; r < 30; r++) begin
            n  = $urandom_range(1, 8);
            mi = 0;
            mq = 0;
            for (int k = 0; k < n; k++) begin
                ar[k] = int'($urandom_range(0, 65535)) - 32768;
                ai[k] = int'($urandom_range(0, 65535)) - 32768;
                br[k] = int'($urandom_range(0, 65535)) - 32768;
                bi[k] = int'($urandom_range(0, 65535)) - 32768;
                mi += longint'(ar[k]) * longint'(br[k]) - longint'(ai[k]) * longint'(bi[k]);
                mq += longint'(ar[k]) * longint'(bi[k]) + longint'(ai[k]) * longint'(br[k]);
            end
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 2) == 0) idle(1);
                set_in(1, k == 0, k == n - 1, ar[k], ai[k], 1, br[k], bi[k]);
                if (k == n - 1) ec = cyc;
                tick();
            end
            idle(10);
            check_one($sformatf("rand%0d", r), mi, mq, ec + 4);
        end
        check("random err", err_o, 0);

        // Stream 2 one cycle behind stream 1, samples every other cycle.
        for (int k = 0; k < 4; k++) begin
            set_in(1, k == 0, k == 3, 3, 4, 0, 0, 0);
            if (k == 3) ec = cyc;
            tick();
            set_in(0, 0, 0, 0, 0, 1, 1, -2);
            tick();
        end
        idle(10);
        check_one("skew", 44, -8, ec + 5);
        check("skew err", err_o, 0);

        // Second stream-1 sample while the first is still unpaired is lost.
        set_in(1, 1, 0, 1, 0, 0, 0, 0);
        tick();
        check("drop err before", err_o, 0);
        set_in(1, 0, 0, 5, 5, 0, 0, 0);
        tick();
        check("drop err after", err_o, 1);
        set_in(0, 0, 0, 0, 0, 1, 2, 0);
        tick();
        set_in(1, 0, 1, 0, 1, 1, 0, 1);
        ec = cyc;
        tick();
        idle(10);
        check_one("drop", 1, 0, ec + 4);

        do_reset();
        check("restart err before", err_o, 0);
        set_in(1, 1, 0, 1, 0, 1, 1, 0);
        tick();
        set_in(1, 0, 0, 1, 0, 1, 1, 0);
        tick();
        set_in(1, 1, 1, 2, 0, 1, 1, 0);
        ec = cyc;
        tick();
        idle(10);
        check_one("restart", 2, 0, ec + 4);
        check("restart err", err_o, 1);

        // Reset mid-frame; the tail samples then arrive outside any frame.
        do_reset();
        set_in(1, 1, 0, 3, 4, 1, 1, -2);
        tick();
        set_in(1, 0, 0, 3, 4, 1, 1, -2);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        data_rst_i = 1'b1;
        tick();
        data_rst_i = 1'b0;
        set_in(1, 0, 0, 3, 4, 1, 1, -2);
        tick();
        set_in(1, 0, 1, 3, 4, 1, 1, -2);
        tick();
        idle(10);
        check("midrst pulses", rq.size(), 0);
        check("midrst real", data_i_o, 0);
        check("midrst imag", data_q_o, 0);
        check("midrst err", err_o, 0);
        rq.delete();
        drive_frame(vt[0], ec);
        check_one("after reset", 44, -8, ec + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
